// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encoding and
// register-file constants.
package pipe_ctrl_pkg;

  localparam int CTRL_STATE_W = 2;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [CTRL_STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a
// load in EX is about to write.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  output logic       lu_hazard
);

  // $zero is never a real dependency
  assign lu_hazard = ex_memread & (ex_rt != REG_ZERO) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, MEM-stage redirects
// and data-memory wait with timeout. Optional perf counters: PIPE_PERF_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4:0]              id_rs,
  input  logic [4:0]              id_rt,
  input  logic                    id_uses_rt,
  input  logic                    ex_memread,
  input  logic [4:0]              ex_rt,
  input  logic                    mem_branch_taken,
  input  logic                    mem_jump,
  input  logic                    dmem_req,
  input  logic                    dmem_ready,
  output logic                    pc_en,
  output logic                    if_id_en,
  output logic                    id_ex_en,
  output logic                    ex_mem_en,
  output logic                    mem_wb_en,
  output logic                    pc_sel_branch,
  output logic                    if_id_flush,
  output logic                    id_ex_flush,
  output logic                    ex_mem_flush,
  output logic                    mem_timeout,
  output logic [CTRL_STATE_W-1:0] ctrl_state,
  output logic [31:0]             perf_stall,
  output logic [31:0]             perf_flush
);

  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] CNT_ONE   = TO_W'(1);

  ctrl_state_e     state_r, state_nxt_s;
  logic [TO_W-1:0] cnt_r, cnt_nxt_s;
  logic            mem_timeout_r, timeout_s;
  logic            lu_hazard_s, mem_wait_s, redirect_req_s;
  logic            resolve_s, hz_ok_s;
  logic            pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s;
  logic            pc_sel_s, if_id_flush_s, id_ex_flush_s, ex_mem_flush_s;

  hazard_detect u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .lu_hazard  (lu_hazard_s)
  );

  assign mem_wait_s     = dmem_req & ~dmem_ready;
  assign redirect_req_s = mem_branch_taken | mem_jump;

  // Next-state and control decode; a release out of MEM_WAIT resolves hazards like RUN
  always_comb begin
    pc_en_s        = 1'b0;
    if_id_en_s     = 1'b0;
    id_ex_en_s     = 1'b0;
    ex_mem_en_s    = 1'b0;
    mem_wb_en_s    = 1'b0;
    pc_sel_s       = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_flush_s = 1'b0;
    state_nxt_s    = state_r;
    cnt_nxt_s      = {TO_W{1'b0}};
    timeout_s      = 1'b0;
    resolve_s      = 1'b0;
    hz_ok_s        = 1'b0;
    case (state_r)
      ST_RUN, ST_FLUSH: begin
        if (mem_wait_s) begin
          state_nxt_s = ST_MEM_WAIT;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          resolve_s = 1'b1;
          hz_ok_s   = (state_r == ST_RUN);
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready && (cnt_r < TIMEOUT_C)) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          resolve_s = 1'b1;
          hz_ok_s   = 1'b1;
          timeout_s = ~dmem_ready;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase

    if (resolve_s) begin
      pc_en_s     = 1'b1;
      if_id_en_s  = 1'b1;
      id_ex_en_s  = 1'b1;
      ex_mem_en_s = 1'b1;
      mem_wb_en_s = 1'b1;
      state_nxt_s = ST_RUN;
      if (hz_ok_s && redirect_req_s) begin
        pc_sel_s       = 1'b1;
        if_id_flush_s  = 1'b1;
        id_ex_flush_s  = 1'b1;
        ex_mem_flush_s = 1'b1;
        state_nxt_s    = ST_FLUSH;
      end else if (hz_ok_s && lu_hazard_s) begin
        pc_en_s       = 1'b0;
        if_id_en_s    = 1'b0;
        id_ex_flush_s = 1'b1;
      end else begin
        pc_sel_s = 1'b0;
      end
    end else begin
      pc_sel_s = 1'b0;
    end
  end

  // State, wait counter and timeout pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_RUN;
      cnt_r         <= {TO_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      mem_timeout_r <= timeout_s;
    end
  end

  // Combinational controls are forced low while reset is held
  assign pc_en         = reset_n & pc_en_s;
  assign if_id_en      = reset_n & if_id_en_s;
  assign id_ex_en      = reset_n & id_ex_en_s;
  assign ex_mem_en     = reset_n & ex_mem_en_s;
  assign mem_wb_en     = reset_n & mem_wb_en_s;
  assign pc_sel_branch = reset_n & pc_sel_s;
  assign if_id_flush   = reset_n & if_id_flush_s;
  assign id_ex_flush   = reset_n & id_ex_flush_s;
  assign ex_mem_flush  = reset_n & ex_mem_flush_s;
  assign mem_timeout   = mem_timeout_r;
  assign ctrl_state    = state_r;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_r, perf_flush_r;

  // Stall cycles (PC held) and redirect events, wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 32'd0;
    end else begin
      perf_stall_r <= pc_en_s  ? perf_stall_r : perf_stall_r + 32'd1;
      perf_flush_r <= pc_sel_s ? perf_flush_r + 32'd1 : perf_flush_r;
    end
  end

  assign perf_stall = perf_stall_r;
  assign perf_flush = perf_flush_r;
`else
  assign perf_stall = 32'd0;
  assign perf_flush = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the sequencing rules.
module tb_pipe_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int TMO = 15;

  // {pc,ifid,idex,exmem,memwb en, pc_sel, ifid/idex/exmem flush, mem_timeout, state}
  localparam logic [11:0] V_IDLE     = 12'b11111_0000_0_00;
  localparam logic [11:0] V_STALL    = 12'b00111_0010_0_00;
  localparam logic [11:0] V_REDIR    = 12'b11111_1111_0_00;
  localparam logic [11:0] V_FROZ_RUN = 12'b00000_0000_0_00;
  localparam logic [11:0] V_FROZ_WT  = 12'b00000_0000_0_01;
  localparam logic [11:0] V_REL_WT   = 12'b11111_0000_0_01;
  localparam logic [11:0] V_IDLE_FL  = 12'b11111_0000_0_10;
  localparam logic [11:0] V_IDLE_TO  = 12'b11111_0000_1_00;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, mem_branch_taken, mem_jump, dmem_req, dmem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_sel_branch;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout;
  logic [1:0] ctrl_state;
  logic [31:0] perf_stall, perf_flush;
  logic [11:0] live_vec;

  int checks = 0, passed = 0;

  // behavioural model state
  bit m_wait, m_flush, m_to;
  int m_cnt;
  int unsigned m_stall, m_flushes;
  bit p_frozen, p_redirect, p_stall, p_timeout;
  logic [11:0] exp_vec, act_vec;
  logic [31:0] exp_stall, exp_flush, act_stall, act_flush;

  pipe_ctrl #(.MEM_TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .mem_jump(mem_jump), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .pc_sel_branch(pc_sel_branch), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .mem_timeout(mem_timeout),
    .ctrl_state(ctrl_state), .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  always #5 clk = ~clk;

  assign live_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_sel_branch,
                     if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout, ctrl_state};

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_memread = 1'b0; ex_rt = 5'd0;
    mem_branch_taken = 1'b0; mem_jump = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic model_reset();
    m_wait = 0; m_flush = 0; m_to = 0; m_cnt = 0; m_stall = 0; m_flushes = 0;
  endtask

  // Expected controls for the current cycle from the sequencing rules
  task automatic predict();
    bit lu, redir, hz_ok, pe;
    logic [1:0] st;
    lu = ex_memread && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    redir = mem_branch_taken || mem_jump;
    p_timeout = 0;
    if (m_wait) begin
      p_frozen  = !dmem_ready && (m_cnt < TMO);
      p_timeout = !dmem_ready && (m_cnt >= TMO);
      hz_ok     = 1;
    end else begin
      p_frozen = dmem_req && !dmem_ready;
      hz_ok    = !m_flush;
    end
    p_redirect = !p_frozen && hz_ok && redir;
    p_stall    = !p_frozen && hz_ok && !redir && lu;
    pe = !p_frozen && !p_stall;
    st = m_wait ? 2'd1 : (m_flush ? 2'd2 : 2'd0);
    exp_vec = {pe, pe, !p_frozen, !p_frozen, !p_frozen, p_redirect, p_redirect,
               p_redirect || p_stall, p_redirect, m_to, st};
    exp_stall = PERF ? m_stall : 32'd0;
    exp_flush = PERF ? m_flushes : 32'd0;
  endtask

  task automatic model_advance();
    if (!exp_vec[11]) m_stall++;
    if (p_redirect) m_flushes++;
    m_to = p_timeout;
    if (p_frozen) begin
      m_cnt  = m_wait ? m_cnt + 1 : 1;
      m_wait = 1;
      m_flush = 0;
    end else begin
      m_wait = 0; m_cnt = 0; m_flush = p_redirect;
    end
  endtask

  // One clock: inputs already driven; sample at negedge, advance model at posedge
  task automatic run_cycle();
    @(negedge clk);
    predict();
    act_vec = live_vec; act_stall = perf_stall; act_flush = perf_flush;
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    model_reset();
    for (int i = 0; i < 4; i++) begin
      {id_uses_rt, ex_memread, mem_branch_taken, mem_jump, dmem_req} = 5'($urandom);
      dmem_ready = 1'($urandom);
      id_rs = 5'd7; ex_rt = 5'd7;
      #3;
      checks++;
      if (live_vec !== 12'd0 || perf_stall !== 32'd0 || perf_flush !== 32'd0)
        $display("FAIL reset_outputs got=%b/%0d/%0d want=0", live_vec, perf_stall, perf_flush);
      else passed++;
    end
    clear_inputs();
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_cycle();
    checks++;
    if (act_vec !== V_IDLE) $display("FAIL reset_idle got=%b want=%b", act_vec, V_IDLE);
    else passed++;
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    run_cycle();
    checks++;
    if (act_vec !== V_STALL) $display("FAIL lu_rs got=%b want=%b", act_vec, V_STALL);
    else passed++;
    ex_memread = 1'b0;
    run_cycle();
    checks++;
    if (act_vec !== V_IDLE) $display("FAIL lu_after got=%b want=%b", act_vec, V_IDLE);
    else passed++;
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    run_cycle();
    checks++;
    if (act_vec !== V_IDLE) $display("FAIL lu_zero got=%b want=%b", act_vec, V_IDLE);
    else passed++;
    ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
    run_cycle();
    checks++;
    if (act_vec !== V_IDLE) $display("FAIL lu_rt_unused got=%b want=%b", act_vec, V_IDLE);
    else passed++;
    id_uses_rt = 1'b1;
    run_cycle();
    checks++;
    if (act_vec !== V_STALL) $display("FAIL lu_rt got=%b want=%b", act_vec, V_STALL);
    else passed++;
    clear_inputs();
    run_cycle();
  endtask

  task automatic test_redirect();
    clear_inputs();
    mem_branch_taken = 1'b1; ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    run_cycle();
    checks++;
    if (act_vec !== V_REDIR) $display("FAIL redir_over_lu got=%b want=%b", act_vec, V_REDIR);
    else passed++;
    run_cycle();
    checks++;
    if (act_vec !== V_IDLE_FL) $display("FAIL flush_suppress got=%b want=%b", act_vec, V_IDLE_FL);
    else passed++;
    clear_inputs();
    run_cycle();
    checks++;
    if (act_vec !== V_IDLE) $display("FAIL flush_to_run got=%b want=%b", act_vec, V_IDLE);
    else passed++;
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      checks++;
      if (act_vec !== ((i == 0) ? V_FROZ_RUN : V_FROZ_WT))
        $display("FAIL mem_wait_frozen[%0d] got=%b", i, act_vec);
      else passed++;
    end
    dmem_ready = 1'b1;
    run_cycle();
    checks++;
    if (act_vec !== V_REL_WT) $display("FAIL mem_release got=%b want=%b", act_vec, V_REL_WT);
    else passed++;
    clear_inputs();
    run_cycle();
    checks++;
    if (act_vec !== V_IDLE) $display("FAIL mem_no_timeout got=%b want=%b", act_vec, V_IDLE);
    else passed++;
  endtask

  task automatic test_timeout();
    logic [31:0] stall0;
    clear_inputs();
    stall0 = perf_stall;
    dmem_req = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      run_cycle();
      checks++;
      if (act_vec !== ((i == 0) ? V_FROZ_RUN : V_FROZ_WT))
        $display("FAIL timeout_frozen[%0d] got=%b", i, act_vec);
      else passed++;
    end
    run_cycle();
    checks++;
    if (act_vec !== V_REL_WT) $display("FAIL timeout_release got=%b want=%b", act_vec, V_REL_WT);
    else passed++;
    checks++;
    if (act_stall - stall0 !== (PERF ? 32'd15 : 32'd0))
      $display("FAIL timeout_perf got=%0d want=%0d", act_stall - stall0, PERF ? 15 : 0);
    else passed++;
    dmem_req = 1'b0;
    run_cycle();
    checks++;
    if (act_vec !== V_IDLE_TO) $display("FAIL timeout_pulse got=%b want=%b", act_vec, V_IDLE_TO);
    else passed++;
    run_cycle();
    checks++;
    if (act_vec !== V_IDLE) $display("FAIL timeout_pulse_end got=%b want=%b", act_vec, V_IDLE);
    else passed++;
  endtask

  task automatic test_reset_mid_wait();
    int frozen;
    clear_inputs();
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (live_vec !== 12'd0 || perf_stall !== 32'd0)
      $display("FAIL reset_mid_wait got=%b/%0d want=0", live_vec, perf_stall);
    else passed++;
    model_reset();
    #1 reset_n = 1'b1;
    checks++;
    if (ctrl_state !== 2'd0) $display("FAIL reset_state got=%0d want=0", ctrl_state);
    else passed++;
    frozen = 0;
    for (int i = 0; i < 40 && (frozen == i); i++) begin
      run_cycle();
      if (act_vec[11:7] === 5'b00000) frozen++;
    end
    checks++;
    if (frozen !== TMO) $display("FAIL reset_wait_restart got=%0d want=%0d", frozen, TMO);
    else passed++;
    clear_inputs();
    for (int i = 0; i < 2; i++) run_cycle();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_memread = 1'($urandom_range(0, 1));
      mem_branch_taken = ($urandom_range(0, 9) == 0);
      mem_jump = ($urandom_range(0, 19) == 0);
      dmem_req = ($urandom_range(0, 3) == 0);
      dmem_ready = ((i / 500) % 2 == 1) ? ($urandom_range(0, 19) == 0) : 1'($urandom_range(0, 1));
      run_cycle();
      checks++;
      if (act_vec !== exp_vec || act_stall !== exp_stall || act_flush !== exp_flush) begin
        bad++;
        $display("FAIL random[%0d] got=%b/%0d/%0d want=%b/%0d/%0d", i, act_vec, act_stall,
                 act_flush, exp_vec, exp_stall, exp_flush);
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. It drives the enable inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and generates bubble/flush requests for them. It resolves three conditions:
- load-use hazards, by stalling and inserting a bubble;
- taken branches and jumps resolved in MEM, by redirecting and flushing;
- multi-cycle data-memory accesses, by freezing the pipeline under a ready handshake with a timeout.

Parameters:
MEM_TIMEOUT, 15, maximum wait cycles for dmem_ready before a forced release (1..255).
TO_W, 8, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt (R-type, store, beq)
ex_memread  in  1  ID/EX MemRead
ex_rt  in  5  ID/EX rt destination
mem_branch_taken  in  1  EX/MEM Branch AND zero flag
mem_jump  in  1  EX/MEM Jump
dmem_req  in  1  EX/MEM MemRead OR MemWrite
dmem_ready  in  1  data memory has completed the current access
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID enable
id_ex_en  out  1  ID/EX enable
ex_mem_en  out  1  EX/MEM enable
mem_wb_en  out  1  MEM/WB enable
pc_sel_branch  out  1  PC mux selects EX/MEM PC (redirect)
if_id_flush  out  1  load NOP into IF/ID on this edge
id_ex_flush  out  1  zero ID/EX control bits on this edge
ex_mem_flush  out  1  zero EX/MEM control bits on this edge
mem_timeout  out  1  one-cycle pulse on forced release
ctrl_state  out  2  current FSM state (debug)
perf_stall  out  32  stall-cycle count (PERF_CNT_EN only, else 0)
perf_flush  out  32  flush-event count (PERF_CNT_EN only, else 0)

Behaviour:
Reset and output style:
- Reset values: state RUN, wait counter 0, perf counters 0.
- While reset_n is low, every output is 0.
- All outputs are combinational from the state and the current inputs. The only registered elements are the state, the wait counter, mem_timeout and the perf counters.

FSM:
- States: RUN=0, MEM_WAIT=1, FLUSH=2. Encoding 3 is illegal and goes to RUN.
- Priority inside RUN/FLUSH: memory wait > redirect > load-use.

Memory wait (RUN, dmem_req=1, dmem_ready=0):
- All five enables 0; no flushes asserted.
- Next state MEM_WAIT; counter <= 1.

MEM_WAIT:
- If dmem_ready=0 and counter<MEM_TIMEOUT: hold everything frozen; counter++.
- If dmem_ready=1: release. Enables are evaluated exactly as in RUN with the memory-wait condition ignored, so a redirect or load-use resolves in the same cycle. Counter <= 0; next state RUN, or FLUSH if a redirect fires.
- If counter==MEM_TIMEOUT: same release, and mem_timeout is asserted 1 on the following cycle for 1 cycle.

Redirect (mem_branch_taken or mem_jump):
- pc_sel_branch=1, pc_en=1.
- if_id_flush=id_ex_flush=ex_mem_flush=1.
- All enables 1.
- Next state FLUSH. Redirect penalty is exactly 3 instructions.

Load-use hazard:
- Condition: ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Response: pc_en=0, if_id_en=0, id_ex_flush=1; id_ex_en, ex_mem_en, mem_wb_en =1.
- Stall lasts 1 cycle. No state change.

FLUSH:
- Exactly one cycle.
- Load-use and redirect detection are suppressed (the younger stages hold bubbles).
- Memory wait is still honoured.
- Next state RUN.

Idle: in RUN with no condition active, all enables are 1 and all flushes are 0.

Reset mid-operation: an asynchronous reset in MEM_WAIT returns to RUN immediately and the counter clears. Any pending access is abandoned.

Optional Feature:
PIPE_PERF_CNT_EN defined:
- perf_stall increments on every cycle with pc_en=0.
- perf_flush increments on every redirect.
- Both are 32-bit and wrap modulo 2^32.

Undefined: perf_stall and perf_flush are tied to 0, no counter flops are built, and the ports remain present.

Decomposition:
Shared package pipe_ctrl_pkg:
- state localparams ST_RUN/ST_MEM_WAIT/ST_FLUSH;
- REG_ZERO=5'd0;
- CTRL_STATE_W=2.

Sub-module hazard_detect: a combinational load-use comparator with inputs id_rs, id_rt, id_uses_rt, ex_memread, ex_rt and output lu_hazard. It is instantiated once.

Test Plan:
- ex_memread=1, ex_rt=8, id_rs=8 in RUN -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle; next cycle all en=1.
- ex_memread=1, ex_rt=0, id_rs=0 -> no stall, all en=1.
- mem_branch_taken=1 with load-use condition also true -> pc_sel_branch=1, three flushes=1, pc_en=1; ctrl_state=2 next cycle, then 0.
- dmem_req=1, dmem_ready low for 4 cycles then high -> all en=0 for 4 cycles, en=1 on the 5th; mem_timeout stays 0.
- dmem_ready held low, MEM_TIMEOUT=15 -> release after 15 frozen cycles; mem_timeout=1 for one cycle; with PIPE_PERF_CNT_EN, perf_stall=15.
- reset_n pulsed low during MEM_WAIT -> outputs 0 at once; after release ctrl_state=0 and the counter restarts from 0 on the next wait.
